pakin: RTL and testbench

- Packet reassembler; sits directly downstream of the packet-out serializer on a point-to-point link.
- Receives a message as a sequence of PSZ-bit packets over a four-phase req/ack channel.
- Reassembles each full address/data/redundancy message and buffers it in a small FIFO.
- Delivers each message on a standard message out-channel, also four-phase.

---
 rtl/pakin_pkg.sv | 26 ++
 rtl/pakin_debouncer.sv | 49 ++++
 rtl/pakin.sv | 213 +++++++++++++++++++++
 tb/tb_pakin.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pakin_pkg.sv
// pakin_pkg: shared definitions for the pakin packet reassembler.
//   - default parameter values (packet, field and FIFO sizes, debounce cycles)
//   - send-side FSM state encoding
//   - idx_width(): counter width that stays legal (>=1) for tiny ranges
package pakin_pkg;

    localparam int DEF_PSZ     = 4;
    localparam int DEF_FSZ     = 4;
    localparam int DEF_ASZ     = 6;
    localparam int DEF_DSZ     = 4;
    localparam int DEF_RSZ     = 4;
    localparam int DEF_REQ_CKS = 2;
    localparam int DEF_ACK_CKS = 2;

    typedef enum logic [1:0] {
        SND_IDLE     = 2'd0,
        SND_WAIT_ACK = 2'd1,
        SND_WAIT_REL = 2'd2
    } snd_state_t;

    // Width needed to count 0..n-1, never less than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pakin_debouncer.sv
// pakin_debouncer: filters a handshake line. The output follows the input
// only after the input has differed from the output for CKS consecutive
// clocks; shorter glitches are ignored.
//   clk_i  clock
//   rst_i  asynchronous active-high reset
//   sig_i  raw handshake input
//   sig_o  debounced level (0 in reset)
//   rdy_o  high from the first clock after reset release
module pakin_debouncer
    import pakin_pkg::*;
#(
    parameter int CKS = DEF_REQ_CKS
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic sig_i,
    output logic sig_o,
    output logic rdy_o
);

    localparam int              CNT_W = idx_width(CKS);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CKS - 1);

    logic             sig_q;
    logic             rdy_q;
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sig_q <= 1'b0;
            rdy_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            rdy_q <= 1'b1;
            if (sig_i == sig_q) begin
                cnt_q <= '0;
            end else if (cnt_q == LAST) begin
                sig_q <= sig_i;
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign sig_o = sig_q;
    assign rdy_o = rdy_q;

endmodule

// File: rtl/pakin.sv
// pakin: packet reassembler. Collects TOT_PKS packets of PSZ bits from a
// four-phase req/ack link into one {addr,dat,red} message (red in the LSBs),
// buffers messages in an FSZ-deep FIFO and delivers them on a four-phase
// message channel.
//   gch_clk, gch_reset    clock, asynchronous active-high reset
//   gch_ready             block and both debouncers ready
//   rcv0_pakio/req_in     packet payload / request in
//   rcv0_ack_out          packet acknowledge
//   snd0_addr/dat/red     message out (held stable while req is high)
//   snd0_req_out/ack_in   message handshake
//   redun_err             (NS_PAKIN_REDUN_CHECK_EN only) one-cycle pulse when
//                         a message fails the XOR-fold check and is dropped
// Optional feature macro: NS_PAKIN_REDUN_CHECK_EN.
module pakin
    import pakin_pkg::*;
#(
    parameter int PSZ         = DEF_PSZ,
    parameter int FSZ         = DEF_FSZ,
    parameter int ASZ         = DEF_ASZ,
    parameter int DSZ         = DEF_DSZ,
    parameter int RSZ         = DEF_RSZ,
    parameter int RCV_REQ_CKS = DEF_REQ_CKS,
    parameter int SND_ACK_CKS = DEF_ACK_CKS
) (
    input  logic           gch_clk,
    input  logic           gch_reset,
    output logic           gch_ready,
    input  logic [PSZ-1:0] rcv0_pakio,
    input  logic           rcv0_req_in,
    output logic           rcv0_ack_out,
    output logic [ASZ-1:0] snd0_addr,
    output logic [DSZ-1:0] snd0_dat,
    output logic [RSZ-1:0] snd0_red,
    output logic           snd0_req_out,
    input  logic           snd0_ack_in
`ifdef NS_PAKIN_REDUN_CHECK_EN
    ,
    output logic           redun_err
`endif
);

    localparam int MSZ     = ASZ + DSZ + RSZ;
    localparam int TOT_PKS = (MSZ / PSZ) + 1;
    localparam int ASM_W   = TOT_PKS * PSZ;
    localparam int IDX_W   = idx_width(TOT_PKS);
    localparam int PTR_W   = $clog2(FSZ);
    localparam int CNT_W   = PTR_W + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TOT_PKS - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FSZ);

    logic rcv0_ckd_req, rcv0_rdy, snd0_ckd_ack, snd0_rdy;
    logic rg_rdy_q;

    pakin_debouncer #(.CKS(RCV_REQ_CKS)) u_rcv_db (
        .clk_i(gch_clk), .rst_i(gch_reset), .sig_i(rcv0_req_in),
        .sig_o(rcv0_ckd_req), .rdy_o(rcv0_rdy)
    );

    pakin_debouncer #(.CKS(SND_ACK_CKS)) u_snd_db (
        .clk_i(gch_clk), .rst_i(gch_reset), .sig_i(snd0_ack_in),
        .sig_o(snd0_ckd_ack), .rdy_o(snd0_rdy)
    );

    always_ff @(posedge gch_clk or posedge gch_reset) begin
        if (gch_reset) rg_rdy_q <= 1'b0;
        else           rg_rdy_q <= 1'b1;
    end

    assign gch_ready = rg_rdy_q & rcv0_rdy & snd0_rdy;

    // ---------------- receive / assembly ----------------
    logic [ASM_W-1:0] asm_q, asm_d;
    logic [IDX_W-1:0] idx_q;
    logic             ack_q;
    logic [MSZ-1:0]   push_msg;
    logic             capture, is_last, accept_last, push, pop, red_ok;
    logic [CNT_W-1:0] count_q;
    logic             fifo_full, fifo_empty;

    // Current packet merged into its slot, so the last packet lands in the
    // pushed word in the same cycle it is captured.
    always_comb begin
        asm_d = asm_q;
        for (int k = 0; k < TOT_PKS; k++) begin
            if (idx_q == IDX_W'(k)) asm_d[k*PSZ +: PSZ] = rcv0_pakio;
        end
    end

    assign push_msg    = asm_d[MSZ-1:0];
    assign capture     = rg_rdy_q & rcv0_ckd_req & ~ack_q;
    assign is_last     = (idx_q == LAST_IDX);
    assign fifo_full   = (count_q == FULL_CNT);
    assign fifo_empty  = (count_q == '0);
    // A full FIFO stalls the last packet (no ack) until the sender side pops.
    assign accept_last = capture & is_last & ~fifo_full;
    assign push        = accept_last & red_ok;

`ifdef NS_PAKIN_REDUN_CHECK_EN
    logic [RSZ-1:0] fold;
    logic           redun_err_q;

    // XOR-fold {addr,dat} into RSZ-bit chunks; the top chunk is zero-extended.
    always_comb begin
        fold = '0;
        for (int b = 0; b < ASZ + DSZ; b++) begin
            fold[b % RSZ] ^= push_msg[RSZ + b];
        end
    end

    assign red_ok = (fold == push_msg[RSZ-1:0]);

    always_ff @(posedge gch_clk or posedge gch_reset) begin
        if (gch_reset) redun_err_q <= 1'b0;
        else           redun_err_q <= accept_last & ~red_ok;
    end

    assign redun_err = redun_err_q;
`else
    assign red_ok = 1'b1;
`endif

    always_ff @(posedge gch_clk or posedge gch_reset) begin
        if (gch_reset) begin
            asm_q <= '0;
            idx_q <= '0;
            ack_q <= 1'b0;
        end else if (rg_rdy_q) begin
            if (capture && !is_last) begin
                asm_q <= asm_d;
                idx_q <= idx_q + 1'b1;
                ack_q <= 1'b1;
            end else if (accept_last) begin
                idx_q <= '0;
                ack_q <= 1'b1;
            end else if (!rcv0_ckd_req && ack_q) begin
                ack_q <= 1'b0;
            end
        end
    end

    assign rcv0_ack_out = ack_q;

    // ---------------- message FIFO ----------------
    logic [MSZ-1:0]   mem_q [FSZ];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;

    always_ff @(posedge gch_clk) begin
        if (push) mem_q[wr_ptr_q] <= push_msg;
    end

    // Full is taken from the registered count, so a same-cycle pop never
    // makes room for a push at count==FSZ.
    always_ff @(posedge gch_clk or posedge gch_reset) begin
        if (gch_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // ---------------- send FSM ----------------
    snd_state_t     state_q;
    logic           req_q;
    logic [ASZ-1:0] addr_q;
    logic [DSZ-1:0] dat_q;
    logic [RSZ-1:0] red_q;

    assign pop = rg_rdy_q & (state_q == SND_WAIT_ACK) & snd0_ckd_ack;

    always_ff @(posedge gch_clk or posedge gch_reset) begin
        if (gch_reset) begin
            state_q <= SND_IDLE;
            req_q   <= 1'b0;
            addr_q  <= '0;
            dat_q   <= '0;
            red_q   <= '0;
        end else if (rg_rdy_q) begin
            case (state_q)
                SND_IDLE: begin
                    if (!fifo_empty && !req_q && !snd0_ckd_ack) begin
                        {addr_q, dat_q, red_q} <= mem_q[rd_ptr_q];
                        req_q   <= 1'b1;
                        state_q <= SND_WAIT_ACK;
                    end
                end
                SND_WAIT_ACK: begin
                    if (snd0_ckd_ack) begin
                        req_q   <= 1'b0;
                        state_q <= SND_WAIT_REL;
                    end
                end
                SND_WAIT_REL: begin
                    if (!snd0_ckd_ack) state_q <= SND_IDLE;
                end
                default: state_q <= SND_IDLE;
            endcase
        end
    end

    assign snd0_req_out = req_q;
    assign snd0_addr    = addr_q;
    assign snd0_dat     = dat_q;
    assign snd0_red     = red_q;

endmodule

// File: tb/tb_pakin.sv
// tb_pakin: directed, table-driven bench for pakin (PSZ=4, ASZ=6, DSZ=4,
// RSZ=4, FSZ=4, debounce 2). The bench plays both the packet serializer and
// the message sink. Every table message carries red equal to the XOR-fold of
// {addr,dat}, so the same table serves builds with NS_PAKIN_REDUN_CHECK_EN.
module tb_pakin;

    logic       gch_clk = 1'b0;
    logic       gch_reset;
    logic       gch_ready;
    logic [3:0] rcv0_pakio;
    logic       rcv0_req_in;
    logic       rcv0_ack_out;
    logic [5:0] snd0_addr;
    logic [3:0] snd0_dat;
    logic [3:0] snd0_red;
    logic       snd0_req_out;
    logic       snd0_ack_in;
`ifdef NS_PAKIN_REDUN_CHECK_EN
    logic       redun_err;
`endif

    always #5 gch_clk = ~gch_clk;

    pakin #(
        .PSZ(4), .FSZ(4), .ASZ(6), .DSZ(4), .RSZ(4),
        .RCV_REQ_CKS(2), .SND_ACK_CKS(2)
    ) dut (
        .gch_clk(gch_clk), .gch_reset(gch_reset), .gch_ready(gch_ready),
        .rcv0_pakio(rcv0_pakio), .rcv0_req_in(rcv0_req_in),
        .rcv0_ack_out(rcv0_ack_out),
        .snd0_addr(snd0_addr), .snd0_dat(snd0_dat), .snd0_red(snd0_red),
        .snd0_req_out(snd0_req_out), .snd0_ack_in(snd0_ack_in)
`ifdef NS_PAKIN_REDUN_CHECK_EN
        , .redun_err(redun_err)
`endif
    );

    // pkts: packet k is pkts[4k+3:4k]; expected fields hand-decoded.
    typedef struct packed {
        logic [15:0] pkts;
        logic [5:0]  addr;
        logic [3:0]  dat;
        logic [3:0]  red;
    } vec_t;

    vec_t tbl [6];
    int   errs   = 0;
    int   checks = 0;
    int   acks   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge gch_clk);
        #1;
    endtask

    task automatic wait_ack(input logic v, input string nm);
        for (int i = 0; i < 40 && rcv0_ack_out !== v; i++) step();
        chk(nm, 32'(rcv0_ack_out), 32'(v));
    endtask

    task automatic wait_req(input logic v, input string nm);
        for (int i = 0; i < 40 && snd0_req_out !== v; i++) step();
        chk(nm, 32'(snd0_req_out), 32'(v));
    endtask

    task automatic send_pkt(input logic [3:0] p, input string nm);
        rcv0_pakio  = p;
        rcv0_req_in = 1'b1;
        wait_ack(1'b1, {nm, "_ack"});
        if (rcv0_ack_out === 1'b1) acks++;
        rcv0_req_in = 1'b0;
        wait_ack(1'b0, {nm, "_rel"});
    endtask

    task automatic send_first3(input vec_t v, input string nm);
        for (int k = 0; k < 3; k++) send_pkt(v.pkts[k*4 +: 4], nm);
    endtask

    task automatic send_msg(input vec_t v, input string nm);
        for (int k = 0; k < 4; k++) send_pkt(v.pkts[k*4 +: 4], nm);
    endtask

    task automatic chk_out(input vec_t v, input string nm);
        wait_req(1'b1, {nm, "_req"});
        chk({nm, "_addr"}, 32'(snd0_addr), 32'(v.addr));
        chk({nm, "_dat"},  32'(snd0_dat),  32'(v.dat));
        chk({nm, "_red"},  32'(snd0_red),  32'(v.red));
    endtask

    task automatic recv_msg(input vec_t v, input string nm);
        chk_out(v, nm);
        snd0_ack_in = 1'b1;
        wait_req(1'b0, {nm, "_reqdrop"});
        snd0_ack_in = 1'b0;
    endtask

    // Raise the last packet and confirm the DUT withholds its ack.
    task automatic expect_blocked(input vec_t v, input string nm);
        rcv0_pakio  = v.pkts[15:12];
        rcv0_req_in = 1'b1;
        repeat (10) step();
        chk(nm, 32'(rcv0_ack_out), 32'd0);
    endtask

    task automatic finish_blocked(input string nm);
        wait_ack(1'b1, {nm, "_ack"});
        rcv0_req_in = 1'b0;
        wait_ack(1'b0, {nm, "_rel"});
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{pkts: 16'h23AB, addr: 6'h23, dat: 4'hA, red: 4'hB};
        tbl[1] = '{pkts: 16'hFFF3, addr: 6'h3F, dat: 4'hF, red: 4'h3}; // pad bits set
        tbl[2] = '{pkts: 16'h0000, addr: 6'h00, dat: 4'h0, red: 4'h0};
        tbl[3] = '{pkts: 16'hD551, addr: 6'h15, dat: 4'h5, red: 4'h1}; // pad bits set
        tbl[4] = '{pkts: 16'h2AC4, addr: 6'h2A, dat: 4'hC, red: 4'h4};
        tbl[5] = '{pkts: 16'h0E79, addr: 6'h0E, dat: 4'h7, red: 4'h9};

        gch_reset   = 1'b1;
        rcv0_pakio  = '0;
        rcv0_req_in = 1'b0;
        snd0_ack_in = 1'b0;
        step(); step();
        chk("rst_ack",   32'(rcv0_ack_out), 32'd0);
        chk("rst_req",   32'(snd0_req_out), 32'd0);
        chk("rst_addr",  32'(snd0_addr),    32'd0);
        chk("rst_ready", 32'(gch_ready),    32'd0);
        gch_reset = 1'b0;
        step();
        chk("ready_1cyc", 32'(gch_ready), 32'd1);

        // Single message: latency, ack hold and ack count.
        acks = 0;
        send_first3(tbl[0], "single");
        rcv0_pakio  = tbl[0].pkts[15:12];
        rcv0_req_in = 1'b1;
        wait_ack(1'b1, "single_last_ack");
        if (rcv0_ack_out === 1'b1) acks++;
        chk("lat_req_low", 32'(snd0_req_out), 32'd0);
        step();
        chk("lat_req_high", 32'(snd0_req_out), 32'd1);
        rcv0_req_in = 1'b0;
        step();
        chk("ack_hold1", 32'(rcv0_ack_out), 32'd1);
        step();
        chk("ack_hold2", 32'(rcv0_ack_out), 32'd1);
        step();
        chk("ack_release", 32'(rcv0_ack_out), 32'd0);
        chk("ack_count", 32'(acks), 32'd4);
        recv_msg(tbl[0], "single");

        // One-cycle req glitch must not be captured or advance the index.
        rcv0_pakio  = 4'hF;
        rcv0_req_in = 1'b1;
        step();
        rcv0_req_in = 1'b0;
        repeat (5) step();
        chk("glitch_no_ack", 32'(rcv0_ack_out), 32'd0);

        // Table sweep.
        for (int i = 0; i < 6; i++) begin
            send_msg(tbl[i], $sformatf("tbl%0d", i));
            recv_msg(tbl[i], $sformatf("tbl%0d", i));
        end

        // Backpressure: four messages fill the FIFO, the fifth stalls.
        for (int i = 0; i < 4; i++) send_msg(tbl[i], $sformatf("bp%0d", i));
        send_first3(tbl[4], "bp4");
        expect_blocked(tbl[4], "bp_blocked");
        recv_msg(tbl[0], "bp_out0");
        finish_blocked("bp_unblock");
        for (int i = 1; i < 5; i++) recv_msg(tbl[i], $sformatf("bp_out%0d", i));

        // Push and pop in the same cycle at count 2.
        send_msg(tbl[1], "pp1");
        send_msg(tbl[2], "pp2");
        send_first3(tbl[3], "pp3");
        chk_out(tbl[1], "pp_head");
        rcv0_pakio  = tbl[3].pkts[15:12];
        rcv0_req_in = 1'b1;
        snd0_ack_in = 1'b1;
        wait_ack(1'b1, "pp_last_ack");
        rcv0_req_in = 1'b0;
        wait_req(1'b0, "pp_pop");
        snd0_ack_in = 1'b0;
        wait_ack(1'b0, "pp_last_rel");
        // Count must be 2 now: two more fit, a third stalls.
        send_msg(tbl[4], "pp4");
        send_msg(tbl[5], "pp5");
        send_first3(tbl[0], "pp0");
        expect_blocked(tbl[0], "pp_full");
        recv_msg(tbl[2], "pp_out2");
        finish_blocked("pp_unblock");
        recv_msg(tbl[3], "pp_out3");
        recv_msg(tbl[4], "pp_out4");
        recv_msg(tbl[5], "pp_out5");
        recv_msg(tbl[0], "pp_out0");

        // Reset in the middle of a message, with a message on the output.
        send_msg(tbl[5], "mr5");
        send_pkt(tbl[0].pkts[3:0], "mr0");
        rcv0_pakio  = tbl[0].pkts[7:4];
        rcv0_req_in = 1'b1;
        wait_ack(1'b1, "mr_pkt1_ack");
        gch_reset = 1'b1;
        #1;
        chk("mr_ack",   32'(rcv0_ack_out), 32'd0);
        chk("mr_req",   32'(snd0_req_out), 32'd0);
        chk("mr_addr",  32'(snd0_addr),    32'd0);
        chk("mr_dat",   32'(snd0_dat),     32'd0);
        chk("mr_red",   32'(snd0_red),     32'd0);
        chk("mr_ready", 32'(gch_ready),    32'd0);
        rcv0_req_in = 1'b0;
        step(); step();
        gch_reset = 1'b0;
        step();
        chk("mr_ready_back", 32'(gch_ready), 32'd1);
        send_msg(tbl[0], "mr_after");
        recv_msg(tbl[0], "mr_after");
        repeat (8) step();
        chk("mr_no_stale", 32'(snd0_req_out), 32'd0);

`ifdef NS_PAKIN_REDUN_CHECK_EN
        // tbl[0] with red 0x5 instead of the fold value 0xB.
        begin
            vec_t bad;
            bad = '{pkts: 16'h23A5, addr: 6'h23, dat: 4'hA, red: 4'h5};
            send_first3(bad, "red_bad");
            rcv0_pakio  = bad.pkts[15:12];
            rcv0_req_in = 1'b1;
            wait_ack(1'b1, "red_bad_ack");
            chk("red_err_pulse", 32'(redun_err), 32'd1);
            step();
            chk("red_err_clear", 32'(redun_err), 32'd0);
            rcv0_req_in = 1'b0;
            wait_ack(1'b0, "red_bad_rel");
            repeat (6) step();
            chk("red_dropped", 32'(snd0_req_out), 32'd0);
            send_msg(tbl[0], "red_good");
            chk("red_good_noerr", 32'(redun_err), 32'd0);
            recv_msg(tbl[0], "red_good");
        end
`endif

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
